icache_controller: RTL and testbench
====================================

// Module: icache_controller
// PURPOSE
//  Direct-mapped, one-word-per-line instruction cache between the Fetcher and the MemoryController.
//  Hits return the instruction one cycle after the request, without using the RAM port.
//  Misses issue one fetch to MemoryController, fill the line and forward the word.
//  Cuts RAM-port contention, so LOAD/STORE traffic is starved less often.
// PARAMETERS
//  INDEX_WIDTH  8   line count = 2**INDEX_WIDTH; index = addr[INDEX_WIDTH+1:2]
//  ADDR_WIDTH   32  address/word width; tag = addr[ADDR_WIDTH-1:INDEX_WIDTH+2]
// PORTS
//  clk                  in   1   clock, rising edge
//  rst_n                in   1   reset, asynchronous, active-low
//  rob_rollback_in      in   1   ReorderBuffer rollback: cancel outstanding fetch
//  fet_request_in       in   1   Fetcher request, 1-cycle pulse
//  fet_address_in       in   32  fetch PC, word aligned
//  fet_ready_out        out  1   1-cycle pulse: fet_instruction_out valid
//  fet_instruction_out  out  32  instruction word
//  mc_request_out       out  1   1-cycle pulse to MemoryController fet_request_in
//  mc_address_out       out  32  miss address, addr[1:0] forced to 0
//  mc_ready_in          in   1   MemoryController fet_ready_out
//  mc_instruction_in    in   32  MemoryController fet_instruction_out
// BEHAVIOUR
//  Reset (rst_n=0, async): all valid bits=0, state=IDLE, all outputs=0.
//  Defaults every cycle: fet_ready_out=0, mc_request_out=0.
//  States: IDLE, MISS.
//  IDLE, fet_request_in=1, no rollback:
//   - hit (valid[idx] && tag match && cacheable): next cycle fet_ready_out=1 with data. State stays IDLE.
//   - otherwise: next cycle mc_request_out=1, mc_address_out={addr[31:2],2'b00}.
//     Latch idx/tag/cacheable. State -> MISS.
//  MISS, mc_ready_in=1, no rollback:
//   - next cycle fet_ready_out=1, fet_instruction_out=mc_instruction_in.
//   - if cacheable: data/tag written, valid[idx]=1.
//   - State -> IDLE.
//  Non-cacheable: addr[17:16]==2'b11 (IO space). Always treated as a miss; never filled.
//  Rollback has priority over everything:
//   - state -> IDLE; no fet_ready_out next cycle.
//   - fet_request_in in the same cycle is dropped (MemoryController also drops it).
//   - A hit pending from the previous cycle is still delivered; the Fetcher discards it.
//   - rollback && mc_ready_in in MISS: the line is still filled (if cacheable), not forwarded.
//  mc_ready_in in IDLE (stale): ignored, no fill.
//  fet_request_in in MISS: protocol violation; ignored, no state change.
//  Back-to-back hits: one per cycle, each returned the following cycle.
//  Miss latency = 1 cycle + MemoryController latency + 1 cycle.
//  mc_address_out holds its value until the next miss.
//  fet_instruction_out holds its value between ready pulses.
//  Array has one write port, used only by fills. The read is combinational on fet_address_in.
// STRUCTURE
//  Shared package (header.v):
//   - ICACHE_IDLE/ICACHE_MISS state codes
//   - IO_REGION bits [17:16]==2'b11 (shared with MemoryController's io_buffer_full check)
//   - TRUE/FALSE, ZERO_WORD
//  Sub-module icache_line_store: valid vector (async reset), tag and data arrays,
//  combinational read, synchronous write.
//  FSM and handshake stay in icache_controller.
// TESTING
//  1. Cold miss: req 0x0000_1000 -> mc_request_out next cycle.
//     mc_ready with 0x0050_0093 -> fet_ready with 0x0050_0093.
//  2. Hit: re-request 0x1000 -> fet_ready next cycle, data 0x0050_0093, mc_request_out stays 0.
//  3. Conflict: req 0x1400 (INDEX_WIDTH=8, same index) -> miss, refill.
//     Next req 0x1000 misses again.
//  4. Rollback in MISS, mc_ready same cycle with 0xDEAD_BEEF -> no fet_ready.
//     Later req to same address hits with 0xDEAD_BEEF.
//  5. IO address 0x0003_0000 requested twice -> two mc_request_out pulses, no fill.
//  6. rst_n low mid-MISS -> outputs 0 immediately, valid cleared.
//     Prior-hit address now misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: FSM state codes, IO region
// decode and common constants.
package icache_pkg;

   typedef enum logic {
      ICACHE_IDLE = 1'b0,
      ICACHE_MISS = 1'b1
   } icache_state_e;

   // IO space is decoded from address bits [17:16]; MemoryController uses the same window.
   localparam int          IO_LSB    = 16;
   localparam logic [1:0]  IO_REGION = 2'b11;

   localparam logic        TRUE      = 1'b1;
   localparam logic        FALSE     = 1'b0;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   function automatic logic is_cacheable(input logic [1:0] region_bits);
      return region_bits != IO_REGION;
   endfunction

endpackage

// File: rtl/icache_line_store.sv
// Direct-mapped line storage: valid bits (async reset), tag and data arrays,
// combinational read port and one synchronous fill port.
module icache_line_store
   import icache_pkg::*;
#(
   parameter  int INDEX_WIDTH = 8,
   parameter  int ADDR_WIDTH  = 32,
   localparam int TAG_W       = ADDR_WIDTH - INDEX_WIDTH - 2,
   localparam int LINES       = 2 ** INDEX_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [INDEX_WIDTH-1:0] rd_idx_i,
   output logic                   rd_valid_o,
   output logic [TAG_W-1:0]       rd_tag_o,
   output logic [ADDR_WIDTH-1:0]  rd_data_o,
   input  logic                   wr_en_i,
   input  logic [INDEX_WIDTH-1:0] wr_idx_i,
   input  logic [TAG_W-1:0]       wr_tag_i,
   input  logic [ADDR_WIDTH-1:0]  wr_data_i
);

   logic [LINES-1:0]      valid_q;
   logic [TAG_W-1:0]      tag_q  [LINES];
   logic [ADDR_WIDTH-1:0] data_q [LINES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= TRUE;
      end
   end

   // Tag/data contents are meaningless until the valid bit is set, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped, one-word-per-line instruction cache between the Fetcher and
// the MemoryController; hits answer in one cycle without touching the RAM port.
module icache_controller
   import icache_pkg::*;
#(
   parameter int INDEX_WIDTH = 8,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rob_rollback_in,
   input  logic                  fet_request_in,
   input  logic [ADDR_WIDTH-1:0] fet_address_in,
   output logic                  fet_ready_out,
   output logic [ADDR_WIDTH-1:0] fet_instruction_out,
   output logic                  mc_request_out,
   output logic [ADDR_WIDTH-1:0] mc_address_out,
   input  logic                  mc_ready_in,
   input  logic [ADDR_WIDTH-1:0] mc_instruction_in
);

   localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

   icache_state_e          state_q, state_d;
   logic                   fet_ready_q, fet_ready_d;
   logic [ADDR_WIDTH-1:0]  fet_instr_q, fet_instr_d;
   logic                   mc_req_q, mc_req_d;
   logic [ADDR_WIDTH-1:0]  mc_addr_q, mc_addr_d;
   logic [INDEX_WIDTH-1:0] miss_idx_q, miss_idx_d;
   logic [TAG_W-1:0]       miss_tag_q, miss_tag_d;
   logic                   miss_cacheable_q, miss_cacheable_d;

   logic [INDEX_WIDTH-1:0] req_idx;
   logic [TAG_W-1:0]       req_tag;
   logic                   req_cacheable;
   logic                   rd_valid;
   logic [TAG_W-1:0]       rd_tag;
   logic [ADDR_WIDTH-1:0]  rd_data;
   logic                   hit;
   logic                   fill_en;

   assign req_idx       = fet_address_in[INDEX_WIDTH+1:2];
   assign req_tag       = fet_address_in[ADDR_WIDTH-1:INDEX_WIDTH+2];
   assign req_cacheable = is_cacheable(fet_address_in[IO_LSB+1:IO_LSB]);
   assign hit           = rd_valid && (rd_tag == req_tag) && req_cacheable;

   // A fill completes even when a rollback cancels the forwarding of the word.
   assign fill_en = (state_q == ICACHE_MISS) && mc_ready_in && miss_cacheable_q;

   icache_line_store #(
      .INDEX_WIDTH(INDEX_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_line_store (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx_i  (req_idx),
      .rd_valid_o(rd_valid),
      .rd_tag_o  (rd_tag),
      .rd_data_o (rd_data),
      .wr_en_i   (fill_en),
      .wr_idx_i  (miss_idx_q),
      .wr_tag_i  (miss_tag_q),
      .wr_data_i (mc_instruction_in)
   );

   always_comb begin
      state_d          = state_q;
      fet_ready_d      = FALSE;
      fet_instr_d      = fet_instr_q;
      mc_req_d         = FALSE;
      mc_addr_d        = mc_addr_q;
      miss_idx_d       = miss_idx_q;
      miss_tag_d       = miss_tag_q;
      miss_cacheable_d = miss_cacheable_q;
      if (rob_rollback_in) begin
         state_d = ICACHE_IDLE;
      end else begin
         case (state_q)
            ICACHE_IDLE: begin
               if (fet_request_in) begin
                  if (hit) begin
                     fet_ready_d = TRUE;
                     fet_instr_d = rd_data;
                  end else begin
                     mc_req_d         = TRUE;
                     mc_addr_d        = {fet_address_in[ADDR_WIDTH-1:2], 2'b00};
                     miss_idx_d       = req_idx;
                     miss_tag_d       = req_tag;
                     miss_cacheable_d = req_cacheable;
                     state_d          = ICACHE_MISS;
                  end
               end
            end
            ICACHE_MISS: begin
               if (mc_ready_in) begin
                  fet_ready_d = TRUE;
                  fet_instr_d = mc_instruction_in;
                  state_d     = ICACHE_IDLE;
               end
            end
            default: state_d = ICACHE_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ICACHE_IDLE;
         fet_ready_q      <= FALSE;
         fet_instr_q      <= '0;
         mc_req_q         <= FALSE;
         mc_addr_q        <= '0;
         miss_idx_q       <= '0;
         miss_tag_q       <= '0;
         miss_cacheable_q <= FALSE;
      end else begin
         state_q          <= state_d;
         fet_ready_q      <= fet_ready_d;
         fet_instr_q      <= fet_instr_d;
         mc_req_q         <= mc_req_d;
         mc_addr_q        <= mc_addr_d;
         miss_idx_q       <= miss_idx_d;
         miss_tag_q       <= miss_tag_d;
         miss_cacheable_q <= miss_cacheable_d;
      end
   end

   assign fet_ready_out       = fet_ready_q;
   assign fet_instruction_out = fet_instr_q;
   assign mc_request_out      = mc_req_q;
   assign mc_address_out      = mc_addr_q;

endmodule

// File: tb/tb_icache_controller.sv
// Self-checking bench for icache_controller: directed scenarios plus a
// randomized run against a line-level behavioural model of the cache.
module tb_icache_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rob_rollback_in = 1'b0;
   logic        fet_request_in = 1'b0;
   logic [31:0] fet_address_in = '0;
   logic        fet_ready_out;
   logic [31:0] fet_instruction_out;
   logic        mc_request_out;
   logic [31:0] mc_address_out;
   logic        mc_ready_in = 1'b0;
   logic [31:0] mc_instruction_in = '0;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: each line remembers the full word address it holds and its data.
   logic        m_valid [256];
   logic [31:0] m_addr  [256];
   logic [31:0] m_data  [256];

   icache_controller #(.INDEX_WIDTH(8), .ADDR_WIDTH(32)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .rob_rollback_in    (rob_rollback_in),
      .fet_request_in     (fet_request_in),
      .fet_address_in     (fet_address_in),
      .fet_ready_out      (fet_ready_out),
      .fet_instruction_out(fet_instruction_out),
      .mc_request_out     (mc_request_out),
      .mc_address_out     (mc_address_out),
      .mc_ready_in        (mc_ready_in),
      .mc_instruction_in  (mc_instruction_in)
   );

   always #5 clk = ~clk;

   function automatic logic model_io(input logic [31:0] a);
      return a[17:16] == 2'b11;
   endfunction

   function automatic logic model_hit(input logic [31:0] a);
      return !model_io(a) && m_valid[a[9:2]] && (m_addr[a[9:2]] == a);
   endfunction

   task automatic model_fill(input logic [31:0] a, input logic [31:0] d);
      if (!model_io(a)) begin
         m_valid[a[9:2]] = 1'b1;
         m_addr[a[9:2]]  = a;
         m_data[a[9:2]]  = d;
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a);
      fet_request_in = 1'b1;
      fet_address_in = a;
      step();
      fet_request_in = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d);
      mc_ready_in       = 1'b1;
      mc_instruction_in = d;
      step();
      mc_ready_in = 1'b0;
   endtask

   task automatic test_reset();
      model_clear();
      #2;
      n_checks++; if (fet_ready_out !== 1'b0) $display("FAIL reset_ready got=%b want=0", fet_ready_out); else n_pass++;
      n_checks++; if (mc_request_out !== 1'b0) $display("FAIL reset_mcreq got=%b want=0", mc_request_out); else n_pass++;
      n_checks++; if (mc_address_out !== 32'h0) $display("FAIL reset_mcaddr got=%h want=0", mc_address_out); else n_pass++;
      n_checks++; if (fet_instruction_out !== 32'h0) $display("FAIL reset_instr got=%h want=0", fet_instruction_out); else n_pass++;
      step();
      rst_n = 1'b1;
      step();
      n_checks++; if (fet_ready_out !== 1'b0) $display("FAIL idle_ready got=%b want=0", fet_ready_out); else n_pass++;
   endtask

   task automatic test_cold_miss();
      issue(32'h0000_1000);
      n_checks++; if ({fet_ready_out, mc_request_out} !== 2'b01) $display("FAIL cold_req got=%b want=01", {fet_ready_out, mc_request_out}); else n_pass++;
      n_checks++; if (mc_address_out !== 32'h0000_1000) $display("FAIL cold_addr got=%h want=00001000", mc_address_out); else n_pass++;
      step();
      n_checks++; if (mc_request_out !== 1'b0) $display("FAIL cold_req_pulse got=%b want=0", mc_request_out); else n_pass++;
      respond(32'h0050_0093);
      model_fill(32'h0000_1000, 32'h0050_0093);
      n_checks++; if ({fet_ready_out, fet_instruction_out} !== {1'b1, 32'h0050_0093}) $display("FAIL cold_fwd got=%b/%h want=1/00500093", fet_ready_out, fet_instruction_out); else n_pass++;
      step();
      n_checks++; if ({fet_ready_out, fet_instruction_out} !== {1'b0, 32'h0050_0093}) $display("FAIL cold_hold got=%b/%h want=0/00500093", fet_ready_out, fet_instruction_out); else n_pass++;
      n_checks++; if (mc_address_out !== 32'h0000_1000) $display("FAIL cold_addr_hold got=%h want=00001000", mc_address_out); else n_pass++;
   endtask

   task automatic test_hit();
      issue(32'h0000_1000);
      n_checks++; if ({fet_ready_out, mc_request_out, fet_instruction_out} !== {2'b10, 32'h0050_0093}) $display("FAIL hit got=%b%b/%h want=10/00500093", fet_ready_out, mc_request_out, fet_instruction_out); else n_pass++;
   endtask

   task automatic test_conflict();
      issue(32'h0000_1400);
      n_checks++; if ({fet_ready_out, mc_request_out, mc_address_out} !== {2'b01, 32'h0000_1400}) $display("FAIL conflict_miss got=%b%b/%h want=01/00001400", fet_ready_out, mc_request_out, mc_address_out); else n_pass++;
      respond(32'h1111_1111);
      model_fill(32'h0000_1400, 32'h1111_1111);
      n_checks++; if ({fet_ready_out, fet_instruction_out} !== {1'b1, 32'h1111_1111}) $display("FAIL conflict_fwd got=%b/%h want=1/11111111", fet_ready_out, fet_instruction_out); else n_pass++;
      issue(32'h0000_1000);
      n_checks++; if ({fet_ready_out, mc_request_out} !== 2'b01) $display("FAIL conflict_evict got=%b want=01", {fet_ready_out, mc_request_out}); else n_pass++;
      respond(32'h0050_0093);
      model_fill(32'h0000_1000, 32'h0050_0093);
      n_checks++; if ({fet_ready_out, fet_instruction_out} !== {1'b1, 32'h0050_0093}) $display("FAIL conflict_refill got=%b/%h want=1/00500093", fet_ready_out, fet_instruction_out); else n_pass++;
   endtask

   task automatic test_back_to_back();
      issue(32'h0000_1008);
      respond(32'h0000_0AAA);
      model_fill(32'h0000_1008, 32'h0000_0AAA);
      fet_request_in = 1'b1;
      fet_address_in = 32'h0000_1000;
      step();
      fet_address_in = 32'h0000_1008;
      n_checks++; if ({fet_ready_out, fet_instruction_out} !== {1'b1, 32'h0050_0093}) $display("FAIL b2b_0 got=%b/%h want=1/00500093", fet_ready_out, fet_instruction_out); else n_pass++;
      step();
      fet_address_in = 32'h0000_1000;
      n_checks++; if ({fet_ready_out, fet_instruction_out} !== {1'b1, 32'h0000_0AAA}) $display("FAIL b2b_1 got=%b/%h want=1/00000aaa", fet_ready_out, fet_instruction_out); else n_pass++;
      step();
      fet_request_in = 1'b0;
      n_checks++; if ({fet_ready_out, mc_request_out, fet_instruction_out} !== {2'b10, 32'h0050_0093}) $display("FAIL b2b_2 got=%b%b/%h want=10/00500093", fet_ready_out, mc_request_out, fet_instruction_out); else n_pass++;
   endtask

   task automatic test_rollback();
      issue(32'h0000_2000);
      n_checks++; if (mc_request_out !== 1'b1) $display("FAIL rb_miss got=%b want=1", mc_request_out); else n_pass++;
      step();
      rob_rollback_in = 1'b1;
      respond(32'hDEAD_BEEF);
      rob_rollback_in = 1'b0;
      model_fill(32'h0000_2000, 32'hDEAD_BEEF);
      n_checks++; if (fet_ready_out !== 1'b0) $display("FAIL rb_no_fwd got=%b want=0", fet_ready_out); else n_pass++;
      issue(32'h0000_2000);
      n_checks++; if ({fet_ready_out, mc_request_out, fet_instruction_out} !== {2'b10, 32'hDEAD_BEEF}) $display("FAIL rb_fill_hit got=%b%b/%h want=10/deadbeef", fet_ready_out, mc_request_out, fet_instruction_out); else n_pass++;
      rob_rollback_in = 1'b1;
      issue(32'h0000_3000);
      rob_rollback_in = 1'b0;
      n_checks++; if ({fet_ready_out, mc_request_out} !== 2'b00) $display("FAIL rb_drop_req got=%b want=00", {fet_ready_out, mc_request_out}); else n_pass++;
      respond(32'h1234_5678);
      n_checks++; if (fet_ready_out !== 1'b0) $display("FAIL stale_ready got=%b want=0", fet_ready_out); else n_pass++;
      issue(32'h0000_3000);
      n_checks++; if ({fet_ready_out, mc_request_out} !== 2'b01) $display("FAIL stale_no_fill got=%b want=01", {fet_ready_out, mc_request_out}); else n_pass++;
      respond(32'hCAFE_0001);
      model_fill(32'h0000_3000, 32'hCAFE_0001);
   endtask

   task automatic test_io();
      issue(32'h0003_0000);
      n_checks++; if ({mc_request_out, mc_address_out} !== {1'b1, 32'h0003_0000}) $display("FAIL io_miss1 got=%b/%h want=1/00030000", mc_request_out, mc_address_out); else n_pass++;
      respond(32'hAAAA_0001);
      n_checks++; if ({fet_ready_out, fet_instruction_out} !== {1'b1, 32'hAAAA_0001}) $display("FAIL io_fwd1 got=%b/%h want=1/aaaa0001", fet_ready_out, fet_instruction_out); else n_pass++;
      issue(32'h0003_0000);
      n_checks++; if ({fet_ready_out, mc_request_out} !== 2'b01) $display("FAIL io_miss2 got=%b want=01", {fet_ready_out, mc_request_out}); else n_pass++;
      respond(32'hAAAA_0002);
      n_checks++; if ({fet_ready_out, fet_instruction_out} !== {1'b1, 32'hAAAA_0002}) $display("FAIL io_fwd2 got=%b/%h want=1/aaaa0002", fet_ready_out, fet_instruction_out); else n_pass++;
   endtask

   task automatic test_reset_mid_miss();
      issue(32'h0000_1400);
      n_checks++; if (mc_request_out !== 1'b1) $display("FAIL rst_pre got=%b want=1", mc_request_out); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({fet_ready_out, mc_request_out} !== 2'b00) $display("FAIL rst_async_ctl got=%b want=00", {fet_ready_out, mc_request_out}); else n_pass++;
      n_checks++; if ({mc_address_out, fet_instruction_out} !== 64'h0) $display("FAIL rst_async_data got=%h/%h want=0/0", mc_address_out, fet_instruction_out); else n_pass++;
      model_clear();
      step();
      rst_n = 1'b1;
      step();
      issue(32'h0000_2000);
      n_checks++; if ({fet_ready_out, mc_request_out} !== 2'b01) $display("FAIL rst_cleared got=%b want=01", {fet_ready_out, mc_request_out}); else n_pass++;
      respond(32'hDEAD_BEEF);
      model_fill(32'h0000_2000, 32'hDEAD_BEEF);
      n_checks++; if ({fet_ready_out, fet_instruction_out} !== {1'b1, 32'hDEAD_BEEF}) $display("FAIL rst_refill got=%b/%h want=1/deadbeef", fet_ready_out, fet_instruction_out); else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] a, d;
      int          lat, mode;
      for (int n = 0; n < 300; n++) begin
         a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 2) << 2) | ($urandom_range(0, 1) << 31);
         if ($urandom_range(0, 5) == 0) a = a | 32'h0003_0000;
         if ($urandom_range(0, 9) == 0) begin
            rob_rollback_in = 1'b1;
            issue(a);
            rob_rollback_in = 1'b0;
            n_checks++; if ({fet_ready_out, mc_request_out} !== 2'b00) $display("FAIL rnd_rb_req n=%0d a=%h got=%b want=00", n, a, {fet_ready_out, mc_request_out}); else n_pass++;
         end else if (model_hit(a)) begin
            issue(a);
            n_checks++; if ({fet_ready_out, mc_request_out, fet_instruction_out} !== {2'b10, m_data[a[9:2]]}) $display("FAIL rnd_hit n=%0d a=%h got=%b%b/%h want=10/%h", n, a, fet_ready_out, mc_request_out, fet_instruction_out, m_data[a[9:2]]); else n_pass++;
         end else begin
            issue(a);
            n_checks++; if ({fet_ready_out, mc_request_out, mc_address_out} !== {2'b01, a}) $display("FAIL rnd_miss n=%0d a=%h got=%b%b/%h want=01/%h", n, a, fet_ready_out, mc_request_out, mc_address_out, a); else n_pass++;
            lat = $urandom_range(0, 3);
            repeat (lat) begin
               step();
               n_checks++; if ({fet_ready_out, mc_request_out} !== 2'b00) $display("FAIL rnd_wait n=%0d got=%b want=00", n, {fet_ready_out, mc_request_out}); else n_pass++;
            end
            mode = $urandom_range(0, 7);
            d = $urandom;
            if (mode == 0) begin
               rob_rollback_in = 1'b1;
               step();
               rob_rollback_in = 1'b0;
               respond(d);
               n_checks++; if (fet_ready_out !== 1'b0) $display("FAIL rnd_stale n=%0d got=%b want=0", n, fet_ready_out); else n_pass++;
            end else if (mode == 1) begin
               rob_rollback_in = 1'b1;
               respond(d);
               rob_rollback_in = 1'b0;
               model_fill(a, d);
               n_checks++; if (fet_ready_out !== 1'b0) $display("FAIL rnd_rb_fill n=%0d got=%b want=0", n, fet_ready_out); else n_pass++;
            end else begin
               respond(d);
               model_fill(a, d);
               n_checks++; if ({fet_ready_out, fet_instruction_out} !== {1'b1, d}) $display("FAIL rnd_fwd n=%0d a=%h got=%b/%h want=1/%h", n, a, fet_ready_out, fet_instruction_out, d); else n_pass++;
            end
         end
         repeat ($urandom_range(0, 1)) step();
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit();
      test_conflict();
      test_back_to_back();
      test_rollback();
      test_io();
      test_reset_mid_miss();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
